// File: rtl/apb_master_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg : APB FSM state type and default bus widths.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package apb_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

endpackage

`default_nettype wire

// File: rtl/apb_master_arbiter_if.sv
// ---------------------------------------------------------------------------
// apb_master_arbiter_if : shared APB bus signals with master/slave views.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface apb_master_arbiter_if
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

   logic [ADDR_WIDTH-1:0] paddr;
   logic                  pselx;
   logic                  penable;
   logic                  pwrite;
   logic [DATA_WIDTH-1:0] pwdata;
   logic [DATA_WIDTH-1:0] prdata;
   logic                  pready;
   logic                  pslverr;

   modport master (
      output paddr, pselx, penable, pwrite, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  paddr, pselx, penable, pwrite, pwdata,
      output prdata, pready, pslverr
   );

endinterface

`default_nettype wire

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick, searching from ptr+1 upward.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
   parameter  int NUM_REQ = 2,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_valid
);

   int               cand;
   logic [IDX_W-1:0] cand_idx;

   always_comb begin
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = 0;
      cand_idx    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         // ptr+1+i never exceeds 2*NUM_REQ-1, so a single wrap suffices
         cand = int'(ptr) + 1 + i;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         cand_idx = IDX_W'(cand);
         if (!grant_valid && req[cand_idx]) begin
            grant_valid     = 1'b1;
            grant[cand_idx] = 1'b1;
            grant_idx       = cand_idx;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/apb_master_arbiter.sv
// ---------------------------------------------------------------------------
// apb_master_arbiter : round-robin APB master shared by NUM_REQ requesters.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module apb_master_arbiter
   import apb_pkg::*;
#(
   parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter  int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter  int NUM_REQ    = 2,
   parameter  int TIMEOUT    = 16,
   localparam int IDX_W      = $clog2(NUM_REQ),
   localparam int CNT_W      = $clog2(TIMEOUT)
) (
   input  logic                          pclk,
   input  logic                          presetn,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ-1:0]            req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic                          rsp_err,
   apb_master_arbiter_if.master          apb
);

   apb_state_e            state_q, state_d;
   logic [IDX_W-1:0]      ptr_q;
   logic [IDX_W-1:0]      gidx_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [ADDR_WIDTH-1:0] paddr_q;
   logic                  pwrite_q;
   logic [DATA_WIDTH-1:0] pwdata_q;
   logic [NUM_REQ-1:0]    rsp_valid_q;
   logic [DATA_WIDTH-1:0] rsp_rdata_q;
   logic                  rsp_err_q;

   logic [NUM_REQ-1:0]    grant;
   logic [IDX_W-1:0]      grant_idx;
   logic                  grant_valid;
   logic                  accept;
   logic                  done;
   logic                  abort;

   logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
   logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
   end

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
      .req         (req_valid),
      .ptr         (ptr_q),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      done    = 1'b0;
      abort   = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_valid) begin
               accept  = 1'b1;
               state_d = SETUP;
            end
         end
         SETUP: state_d = ACCESS;
         ACCESS: begin
            // pready takes priority over the timeout limit on the same cycle
            if (apb.pready) begin
               done    = 1'b1;
               state_d = IDLE;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               abort   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (!presetn) begin
         state_q     <= IDLE;
         ptr_q       <= IDX_W'(NUM_REQ - 1);
         gidx_q      <= '0;
         cnt_q       <= '0;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            ptr_q    <= grant_idx;
            gidx_q   <= grant_idx;
            paddr_q  <= addr_arr[grant_idx];
            pwrite_q <= req_write[grant_idx];
            pwdata_q <= wdata_arr[grant_idx];
            cnt_q    <= '0;
         end else if (state_q == ACCESS && !apb.pready && !abort) begin
            cnt_q <= cnt_q + 1'b1;
         end
         rsp_valid_q <= (done || abort) ? (NUM_REQ'(1) << gidx_q) : '0;
         rsp_err_q   <= done ? apb.pslverr : abort;
         rsp_rdata_q <= (done && !pwrite_q) ? apb.prdata : '0;
      end
   end

   assign req_ready   = (state_q == IDLE) ? grant : '0;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign apb.paddr   = paddr_q;
   assign apb.pwrite  = pwrite_q;
   assign apb.pwdata  = pwdata_q;
   assign apb.pselx   = (state_q == SETUP) || (state_q == ACCESS);
   assign apb.penable = (state_q == ACCESS);

endmodule

`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_master_arbiter : directed cycle-accurate checks of the APB arbiter.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_apb_master_arbiter;

   logic        pclk = 1'b0;
   logic        presetn;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [1:0]  req_write;
   logic [15:0] req_addr;
   logic [63:0] req_wdata;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int checks   = 0;
   int failures = 0;

   apb_master_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) apb ();

   apb_master_arbiter #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (8),
      .NUM_REQ    (2),
      .TIMEOUT    (16)
   ) dut (
      .pclk      (pclk),
      .presetn   (presetn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .apb       (apb)
   );

   always #5 pclk = ~pclk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic set_req(input int i, input logic v, input logic w,
                          input logic [7:0] a, input logic [31:0] d);
      req_valid[i]         = v;
      req_write[i]         = w;
      req_addr[i*8 +: 8]   = a;
      req_wdata[i*32 +: 32] = d;
   endtask

   initial begin
      logic [1:0] exp_g;
      logic [7:0] exp_a;
      presetn     = 1'b0;
      req_valid   = '0;
      req_write   = '0;
      req_addr    = '0;
      req_wdata   = '0;
      apb.prdata  = '0;
      apb.pready  = 1'b0;
      apb.pslverr = 1'b0;
      repeat (3) tick();

      check("rst_req_ready", req_ready, 2'b00);
      check("rst_rsp_valid", rsp_valid, 2'b00);
      check("rst_rsp_rdata", rsp_rdata, 32'h0);
      check("rst_rsp_err",   rsp_err, 1'b0);
      check("rst_pselx",     apb.pselx, 1'b0);
      check("rst_penable",   apb.penable, 1'b0);
      check("rst_paddr",     apb.paddr, 8'h00);
      check("rst_pwrite",    apb.pwrite, 1'b0);
      check("rst_pwdata",    apb.pwdata, 32'h0);
      presetn = 1'b1;
      tick();

      // single zero-wait write from requester 0
      set_req(0, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF);
      #1 check("wr_ready", req_ready, 2'b01);
      tick();
      set_req(0, 1'b0, 1'b0, 8'h00, 32'h0);
      check("wr_setup_psel", apb.pselx, 1'b1);
      check("wr_setup_pen",  apb.penable, 1'b0);
      check("wr_setup_addr", apb.paddr, 8'h10);
      check("wr_setup_pwr",  apb.pwrite, 1'b1);
      check("wr_setup_data", apb.pwdata, 32'hDEADBEEF);
      check("wr_setup_rdy",  req_ready, 2'b00);
      apb.pready = 1'b1;
      tick();
      check("wr_access_pen", apb.penable, 1'b1);
      check("wr_access_addr", apb.paddr, 8'h10);
      tick();
      apb.pready = 1'b0;
      check("wr_rsp_valid", rsp_valid, 2'b01);
      check("wr_rsp_err",   rsp_err, 1'b0);
      check("wr_rsp_rdata", rsp_rdata, 32'h0);
      check("wr_rsp_psel",  apb.pselx, 1'b0);

      // read from requester 1 with three wait states
      set_req(1, 1'b1, 1'b0, 8'h24, 32'h0);
      #1 check("rd_ready", req_ready, 2'b10);
      tick();
      set_req(1, 1'b0, 1'b0, 8'h00, 32'h0);
      check("rd_setup_addr", apb.paddr, 8'h24);
      check("rd_setup_pwr",  apb.pwrite, 1'b0);
      tick();
      for (int k = 0; k < 3; k++) begin
         check("rd_wait_pen", apb.penable, 1'b1);
         check("rd_wait_rsp", rsp_valid, 2'b00);
         tick();
      end
      check("rd_last_pen", apb.penable, 1'b1);
      apb.pready = 1'b1;
      apb.prdata = 32'h12345678;
      tick();
      apb.pready = 1'b0;
      apb.prdata = 32'h0;
      check("rd_rsp_valid", rsp_valid, 2'b10);
      check("rd_rsp_rdata", rsp_rdata, 32'h12345678);
      check("rd_rsp_err",   rsp_err, 1'b0);

      // contention: both requesters held, grants alternate every 3 cycles
      set_req(0, 1'b1, 1'b1, 8'h40, 32'hA0A0A0A0);
      set_req(1, 1'b1, 1'b1, 8'h41, 32'hB1B1B1B1);
      for (int n = 0; n < 6; n++) begin
         exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
         exp_a = (n % 2 == 0) ? 8'h40 : 8'h41;
         #1 check("ct_ready", req_ready, exp_g);
         tick();
         check("ct_setup_addr", apb.paddr, exp_a);
         check("ct_setup_rdy",  req_ready, 2'b00);
         apb.pready = 1'b1;
         tick();
         tick();
         apb.pready = 1'b0;
         check("ct_rsp_valid", rsp_valid, exp_g);
         if (n == 5) begin
            req_valid = 2'b00;
         end
      end

      // slave error on a read from requester 0
      set_req(0, 1'b1, 1'b0, 8'h30, 32'h0);
      #1 check("er_ready", req_ready, 2'b01);
      tick();
      set_req(0, 1'b0, 1'b0, 8'h00, 32'h0);
      tick();
      apb.pready  = 1'b1;
      apb.pslverr = 1'b1;
      apb.prdata  = 32'hCAFE0001;
      tick();
      apb.pready  = 1'b0;
      apb.pslverr = 1'b0;
      apb.prdata  = 32'h0;
      check("er_rsp_valid", rsp_valid, 2'b01);
      check("er_rsp_err",   rsp_err, 1'b1);
      check("er_rsp_rdata", rsp_rdata, 32'hCAFE0001);

      // timeout: pready never arrives
      set_req(1, 1'b1, 1'b1, 8'h50, 32'h55AA55AA);
      #1 check("to_ready", req_ready, 2'b10);
      tick();
      set_req(1, 1'b0, 1'b0, 8'h00, 32'h0);
      tick();
      for (int k = 0; k < 16; k++) begin
         check("to_wait_pen", apb.penable, 1'b1);
         check("to_wait_rsp", rsp_valid, 2'b00);
         tick();
      end
      check("to_rsp_valid", rsp_valid, 2'b10);
      check("to_rsp_err",   rsp_err, 1'b1);
      check("to_rsp_rdata", rsp_rdata, 32'h0);
      check("to_psel",      apb.pselx, 1'b0);
      check("to_pen",       apb.penable, 1'b0);

      // reset during ACCESS of a requester-0 transfer
      tick();
      set_req(0, 1'b1, 1'b1, 8'h60, 32'h01020304);
      #1 check("mr_ready", req_ready, 2'b01);
      tick();
      set_req(0, 1'b0, 1'b0, 8'h00, 32'h0);
      tick();
      check("mr_access_pen", apb.penable, 1'b1);
      presetn = 1'b0;
      tick();
      check("mr_psel",  apb.pselx, 1'b0);
      check("mr_pen",   apb.penable, 1'b0);
      check("mr_rsp",   rsp_valid, 2'b00);
      presetn = 1'b1;
      tick();
      check("mr_rsp_after", rsp_valid, 2'b00);
      req_valid = 2'b11;
      #1 check("mr_first_grant", req_ready, 2'b01);
      req_valid = 2'b00;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Shares the single APB bus between `NUM_REQ` internal requesters and drives the APB master side of the bus: paddr, pselx, penable, pwrite and pwdata. Each cycle it may accept one request, chosen by round-robin. It then sequences the transfer through the APB SETUP and ACCESS phases, guards the ACCESS phase with a wait-state timeout, and returns read data and error status to the requester that won. It sits between the block-level requesters and the APB slaves on the shared APB bus interface.

## Interface
Parameters:
- `DATA_WIDTH`, 32, APB data width.
- `ADDR_WIDTH`, 8, APB address width.
- `NUM_REQ`, 2, number of requesters (≥2).
- `TIMEOUT`, 16, maximum number of ACCESS cycles without pready before the transfer is aborted (≥2).

Ports:
- `pclk`  in  1  clock; one clock domain. All logic is on the rising edge.
- `presetn`  in  1  reset, synchronous and active-low.
- `req_valid`  in  NUM_REQ  one request-pending bit per requester.
- `req_ready`  out  NUM_REQ  one-hot accept. A request is accepted when req_valid[i] and req_ready[i] are both high.
- `req_write`  in  NUM_REQ  per-requester direction: 1 means write.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  packed; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_wdata`  in  NUM_REQ*DATA_WIDTH  packed; same slicing rule as req_addr.
- `rsp_valid`  out  NUM_REQ  one-cycle completion pulse to the requester that was granted.
- `rsp_rdata`  out  DATA_WIDTH  read data. Valid when any rsp_valid bit is high; 0 for writes and for timeouts.
- `rsp_err`  out  1  captured pslverr, or 1 on timeout. Valid together with rsp_valid.
- `paddr`  out  ADDR_WIDTH, `pselx`  out  1, `penable`  out  1, `pwrite`  out  1, `pwdata`  out  DATA_WIDTH  APB master outputs.
- `prdata`  in  DATA_WIDTH, `pready`  in  1, `pslverr`  in  1  APB slave responses.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- **IDLE**
  - If any req_valid bit is high, the arbiter grants one index g by round-robin. The search starts at the index after the last granted one.
  - req_ready[g] is driven combinationally in the same cycle.
  - On that edge the block registers paddr, pwrite and pwdata from requester g, stores g, moves the round-robin pointer to g, and goes to SETUP.
  - req_ready is 0 in every state other than IDLE.
- **SETUP**: pselx=1, penable=0. Always lasts exactly one cycle, then goes to ACCESS.
- **ACCESS**: pselx=1, penable=1. The wait counter increments every cycle pready is low.
  - When pready=1: capture prdata (reads only; writes return 0) and pslverr, pulse rsp_valid[g] on the next cycle, return to IDLE.
  - When the counter reaches TIMEOUT−1 and pready is still low: abort, pulse rsp_valid[g] with rsp_err=1 and rsp_rdata=0, return to IDLE.
  - The counter clears on entry to SETUP.
- paddr, pwrite and pwdata stay stable from SETUP to the end of ACCESS. In IDLE they hold their last value.
- Requesters hold req_* stable while req_valid is high and until the accept cycle.
- There is no response backpressure; the requester must consume the rsp_valid pulse when it arrives.

## Timing
- Reset values: every output is 0 (req_ready, rsp_*, paddr, pselx, penable, pwrite, pwdata). FSM is IDLE, round-robin pointer is NUM_REQ−1 so requester 0 has first priority, counter is 0.
- Latency with a zero-wait slave:
  - accept at cycle T
  - SETUP at T+1
  - ACCESS with pready at T+2
  - rsp_valid at T+3
- Each slave wait state adds one cycle.
- Peak throughput is one transfer per 3 cycles, because the block always returns to IDLE. It can accept again in the cycle rsp_valid is high.
- Simultaneous req_valid bits: exactly one req_ready, following round-robin order. A requester that keeps req_valid high is granted at most once per NUM_REQ grants while others are also requesting.
- pready arriving on the same cycle as the timeout limit counts as success; pready wins.
- pslverr is sampled only when pready=1. pready is ignored outside ACCESS.
- Reset asserted mid-transfer: on the next pclk edge pselx and penable drop to 0 and no rsp_valid is issued for the aborted transfer.

## Structure
- Package `apb_pkg` holds:
  - `apb_state_e` (IDLE, SETUP, ACCESS), shared with the APB slave blocks.
  - Localparams for the default data and address widths.
- Sub-module `rr_arbiter` (parameter NUM_REQ) takes the request vector and pointer and returns a one-hot grant plus a binary index. It is purely combinational.
- The pointer register, FSM and counter live in the top module.

## Test plan
- Single write: req0 write, addr 0x10, data 0xDEADBEEF, zero-wait slave -> APB setup at T+1, access at T+2, rsp_valid[0] at T+3 with rsp_err=0 and rsp_rdata=0.
- Read with 3 wait states: req1 read, addr 0x24, slave returns 0x12345678 -> penable held for 4 cycles, rsp_valid[1] at T+6 with rsp_rdata=0x12345678.
- Contention: req0 and req1 held high continuously, 6 transfers -> grants alternate 0,1,0,1,0,1, with 3 cycles per transfer.
- Slave error: read with pslverr=1 together with pready -> rsp_err=1, rsp_rdata=prdata.
- Timeout: pready stuck low, TIMEOUT=16 -> penable high for 16 cycles, then rsp_valid with rsp_err=1 and rsp_rdata=0, pselx=0 next cycle.
- Mid-transfer reset: presetn low during ACCESS -> pselx=penable=0 on the next edge, no rsp_valid, and the first request after reset goes to requester 0.
